// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage types and constants.
// FSM encodings, instruction size, default reset PC and address helpers.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word index presented to the instruction memory.
  function automatic logic [31:0] word_idx(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

  // Byte address is not on a 32-bit instruction boundary.
  function automatic logic misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction memory port: word-indexed address out, data back.
// master = fetch controller, slave = instruction memory.
interface fetch_controller_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );

endinterface

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, drives instruction memory, feeds IF/ID.
// Ports: clk/reset, imem (master), stall/redirect/halt in, IF/ID, fault, count, state out.
module fetch_controller
  import mips_fetch_pkg::*;
#(
  parameter int          MEM_SIZE = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                      clk,
  input  logic                      reset,
  fetch_controller_if.master        imem,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      halt_req,
  output logic                      if_valid,
  output logic [31:0]               if_instr,
  output logic [31:0]               if_pc,
  output logic [31:0]               if_pc_plus4,
  output logic                      fault,
  output logic [31:0]               fault_pc,
  output logic [31:0]               fetch_count,
  output logic [1:0]                state
);

  localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);
  localparam logic [31:0] STEP      = 32'(INSTR_BYTES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        fault_q, fault_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] cnt_q, cnt_d;

  logic        out_of_range;
  logic [31:0] pc_next;
  logic [31:0] cnt_inc;

  assign out_of_range = word_idx(pc_q) >= MEM_WORDS;
  assign pc_next      = pc_q + STEP;
  assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      ifpc4_q <= '0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end

      RUN: begin
        // Redirect beats both the range check and stall.
        if (halt_req) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          valid_d = 1'b0;
          if (misaligned(redirect_pc)) begin
            state_d = FAULT;
            fault_d = 1'b1;
            fpc_d   = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (out_of_range) begin
          state_d = FAULT;
          fault_d = 1'b1;
          fpc_d   = pc_q;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem.imem_data;
          ifpc_d  = pc_q;
          ifpc4_d = pc_next;
          valid_d = 1'b1;
          pc_d    = pc_next;
          cnt_d   = cnt_inc;
        end
      end

      HALT, FAULT: begin
        // Terminal until reset.
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem.imem_addr = word_idx(pc_q);

  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus4 = ifpc4_q;
  assign fault       = fault_q;
  assign fault_pc    = fpc_q;
  assign fetch_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller.
// Directed test-plan steps followed by a randomized run against a behavioural model.
module tb_fetch_controller;

  localparam int MEM_SIZE = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;
  logic [1:0]  state;

  logic [31:0] mem [MEM_SIZE];

  int tests = 0;
  int fails = 0;

  fetch_controller_if imem_if ();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] widx);
    if (widx < 32'(MEM_SIZE)) return mem[widx[4:0]];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_if.imem_data = mem_rd(imem_if.imem_addr);

  fetch_controller #(
    .MEM_SIZE (MEM_SIZE),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem_if.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count),
    .state          (state)
  );

  // Behavioural model: mode 0 boot, 1 running, 2 halted, 3 faulted.
  int          m_mode;
  longint      m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  longint      m_ifpc;
  longint      m_ifpc4;
  bit          m_fault;
  longint      m_fpc;
  longint      m_cnt;

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 0;
    m_valid = 0;
    m_instr = 0;
    m_ifpc  = 0;
    m_ifpc4 = 0;
    m_fault = 0;
    m_fpc   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit rv,
                            input logic [31:0] rpc, input bit h);
    if (r) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (h) begin
        m_mode  = 2;
        m_valid = 0;
      end else if (rv && (rpc % 4 != 0)) begin
        m_mode  = 3;
        m_fault = 1;
        m_fpc   = rpc;
        m_valid = 0;
      end else if (rv) begin
        m_pc    = rpc;
        m_valid = 0;
      end else if (m_pc / 4 >= MEM_SIZE) begin
        m_mode  = 3;
        m_fault = 1;
        m_fpc   = m_pc;
        m_valid = 0;
      end else if (!s) begin
        m_instr = mem[m_pc / 4];
        m_ifpc  = m_pc;
        m_ifpc4 = (m_pc + 4) % 64'h1_0000_0000;
        m_valid = 1;
        m_pc    = (m_pc + 4) % 64'h1_0000_0000;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",  {30'b0, state}, 32'(m_mode));
    check("addr",   imem_if.imem_addr, 32'(m_pc / 4));
    check("valid",  {31'b0, if_valid}, {31'b0, m_valid});
    check("instr",  if_instr, m_instr);
    check("if_pc",  if_pc, 32'(m_ifpc));
    check("pc4",    if_pc_plus4, 32'(m_ifpc4));
    check("fault",  {31'b0, fault}, {31'b0, m_fault});
    check("fpc",    fault_pc, 32'(m_fpc));
    check("count",  fetch_count, 32'(m_cnt));
  endtask

  task automatic cyc(input bit r, input bit s, input bit rv,
                     input logic [31:0] rpc, input bit h);
    reset          = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = h;
    @(posedge clk);
    model_step(r, s, rv, rpc, h);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0);
  endtask

  logic [31:0] snap_instr;
  int          stuck;
  bit          r_r, r_s, r_rv, r_h;
  logic [31:0] r_pc;
  int          sel;

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = $urandom;
    mem[0] = 32'hA000_000A;
    mem[1] = 32'hB000_000B;
    mem[2] = 32'hC000_000C;
    mem[3] = 32'hD000_000D;
    model_reset();

    // Reset values.
    cyc(1, 0, 0, 32'h0, 0);
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);

    // Free run A..D.
    cyc(0, 0, 0, 32'h0, 0);
    check("boot_valid", {31'b0, if_valid}, 32'd0);
    idle(4);
    check("run_instr", if_instr, 32'hD000_000D);
    check("run_pc", if_pc, 32'hC);
    check("run_cnt", fetch_count, 32'd4);

    // Stall while B is on the output.
    cyc(1, 0, 0, 32'h0, 0);
    idle(3);
    check("pre_stall", if_instr, 32'hB000_000B);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 32'h0, 0);
      check("stall_addr", imem_if.imem_addr, 32'd2);
      check("stall_pc", if_pc, 32'h4);
    end
    cyc(0, 0, 0, 32'h0, 0);
    check("post_stall", if_instr, 32'hC000_000C);

    // Redirect together with stall.
    cyc(0, 1, 1, 32'h10, 0);
    check("redir_flush", {31'b0, if_valid}, 32'd0);
    cyc(0, 0, 0, 32'h0, 0);
    check("redir_pc", if_pc, 32'h10);
    check("redir_instr", if_instr, mem[4]);

    // Misaligned redirect, then fault holds under random inputs.
    cyc(0, 0, 1, 32'h0E, 0);
    check("mis_fpc", fault_pc, 32'h0E);
    for (int i = 0; i < 10; i++)
      cyc(0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
    check("mis_state", {30'b0, state}, 32'd3);

    // Sequential run to the last word.
    cyc(1, 0, 0, 32'h0, 0);
    idle(1 + MEM_SIZE);
    check("end_pc", if_pc, 32'h7C);
    cyc(0, 0, 0, 32'h0, 0);
    check("end_fault", {31'b0, fault}, 32'd1);
    check("end_fpc", fault_pc, 32'h80);
    check("end_cnt", fetch_count, 32'(MEM_SIZE));

    // Halt beats redirect; reset recovers.
    cyc(1, 0, 0, 32'h0, 0);
    idle(3);
    cyc(0, 0, 1, 32'h40, 1);
    check("halt_state", {30'b0, state}, 32'd2);
    check("halt_addr", imem_if.imem_addr, 32'd2);
    idle(3);
    cyc(1, 0, 0, 32'h0, 0);
    check("halt_rst", imem_if.imem_addr, 32'd0);
    check("halt_rst_f", {31'b0, fault}, 32'd0);

    // Randomized run.
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      r_r  = ($urandom_range(0, 199) == 0) || (stuck > 6);
      r_s  = ($urandom_range(0, 3) == 0);
      r_rv = ($urandom_range(0, 11) == 0);
      r_h  = ($urandom_range(0, 149) == 0);
      sel  = $urandom_range(0, 19);
      if (sel < 15)      r_pc = {25'b0, 5'($urandom), 2'b00};
      else if (sel < 17) r_pc = {$urandom} | 32'h1;
      else               r_pc = 32'h80 + {$urandom_range(0, 8), 2'b00};
      if (sel == 19) r_pc = 32'h7C;
      cyc(r_r, r_s, r_rv, r_pc, r_h);
      stuck = (m_mode >= 2) ? stuck + 1 : 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction memory: owns the program counter and drives the word-indexed fetch address.
- Registers the returned instruction into an IF/ID output stage with a valid flag.
- Handles stall, branch/jump redirect, halt and address faults.
- Sits between the instruction memory (combinational read, indexed by word) and the decode stage of the MIPS32 core.

Parameters:
- MEM_SIZE, 32, instruction memory depth in 32-bit words; fetches at word index >= MEM_SIZE fault.
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset; must be word aligned.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  word index to instruction memory = {2'b00, pc[31:2]}; combinational from the PC register.
- imem_data  input  32  instruction word returned combinationally by instruction memory.
- stall  input  1  decode hazard; hold PC and IF/ID outputs.
- redirect_valid  input  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  input  32  byte target address.
- halt_req  input  1  stop fetching permanently until reset.
- if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
- if_instr  output  32  fetched instruction.
- if_pc  output  32  byte address of if_instr.
- if_pc_plus4  output  32  if_pc + 4, for link/branch offset.
- fault  output  1  sticky; set in FAULT state.
- fault_pc  output  32  offending byte address.
- fetch_count  output  32  number of instructions delivered with if_valid=1; saturates at 32'hFFFF_FFFF.
- state  output  2  current FSM state encoding.

Behaviour:
- All state updates on rising clk; reset has priority over every other input.
- Reset values: pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_pc_plus4=0; fault=0; fault_pc=0; fetch_count=0; state=BOOT.
- Every control decision depends only on registered state plus current inputs. No combinational path from any input to an output except imem_data into the if_instr register input.
- FSM states:
  - BOOT=0: single cycle with if_valid=0; always goes to RUN.
  - RUN=1: normal fetching.
  - HALT=2: stopped by halt_req.
  - FAULT=3: stopped by an address fault.
- Priority within RUN (highest first): halt_req, then redirect_valid, then range fault, then stall, then normal fetch.
- halt_req: go to HALT, if_valid<=0, pc frozen. HALT and FAULT are exited only by reset; all other inputs are ignored there.
- redirect_valid with redirect_pc[1:0]!=0: go to FAULT, fault<=1, fault_pc<=redirect_pc, if_valid<=0.
- Aligned redirect: pc<=redirect_pc, if_valid<=0 (flush). This applies even while stall=1, i.e. redirect overrides stall.
- Range fault: pc[31:2] >= MEM_SIZE with no redirect pending. Go to FAULT, fault<=1, fault_pc<=pc, if_valid<=0, no latch.
- stall=1: pc, if_valid, if_instr, if_pc, if_pc_plus4 and fetch_count all hold.
- Normal fetch:
  - if_instr<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4.
  - fetch_count increments, saturating.
- Latency: the instruction at PC X appears on if_instr one clk after imem_addr=X>>2 is presented.
- The first valid instruction after reset appears at the end of the second clk after reset deasserts (BOOT cycle plus fetch).
- Arithmetic: pc+4 is modulo 2^32. Wrap is unreachable in practice because the range check fires first.
- Redirect to the last word (MEM_SIZE-1)*4 is legal and is fetched. The following sequential PC then faults.
- Reset mid-operation, including in HALT or FAULT, restores all reset values in the same cycle.

Decomposition:
- Shared package mips_fetch_pkg:
  - state encodings BOOT/RUN/HALT/FAULT;
  - constant INSTR_BYTES=4;
  - default RESET_PC.
- No sub-module is needed; the range/alignment check is a few lines of inline logic.

Test Plan:
- Reset then free run with memory words 0..3 = A,B,C,D: cycle 1 if_valid=0; cycles 2..5 give if_instr=A,B,C,D and if_pc=0,4,8,C; fetch_count=4.
- stall held 3 cycles while if_instr=B: outputs frozen at B/if_pc=4, imem_addr stays 2. On release, C follows with no loss or duplication.
- redirect_valid with redirect_pc=0x10 asserted together with stall: next cycle if_valid=0. The cycle after, if_pc=0x10 and if_instr=mem[4].
- Misaligned redirect_pc=0x0E: next cycle state=FAULT, fault=1, fault_pc=0x0E, if_valid=0; outputs stay constant for 10 further cycles.
- Sequential run to the end, with MEM_SIZE=32: if_pc=0x7C is delivered. The next cycle gives fault=1, fault_pc=0x80, and fetch_count equals the number of delivered words.
- halt_req and redirect_valid in the same cycle: state=HALT, pc unchanged. Reset then returns state=BOOT, pc=RESET_PC and fault=0.
